ps2_scan_decoder: RTL and testbench
===================================

// Module: ps2_scan_decoder
// PURPOSE
//  Consumes 10-bit PS/2 frames from the serial-to-parallel receiver and checks start and parity.
//  Tracks the E0 (extended) and F0 (break) prefix bytes.
//  Emits one make/break key event per complete scan sequence on a valid/ready handshake.
//  Sits between the PS/2 frame receiver and the key-mapping / display logic.
// PARAMETERS
//  TIMEOUT_CYC  50000  clk cycles with no frame_valid before a pending prefix is discarded (1 ms @ 50 MHz)
//  TO_W         16     width of timeout counter; TIMEOUT_CYC must be < 2**TO_W
// PORTS
//  clk          in   1   system clock; all logic on posedge clk
//  res          in   1   reset, asynchronous, active-low (0 = reset)
//  frame_in     in   10  [0]=start, [8:1]=data LSB first, [9]=odd parity
//  frame_valid  in   1   one-cycle strobe, frame_in is valid this cycle (already in clk domain)
//  key_ready    in   1   consumer accepts the event when key_valid & key_ready
//  key_valid    out  1   event pending in output register
//  key_code     out  8   scan code (prefixes stripped)
//  key_ext      out  1   1 = sequence contained E0
//  key_release  out  1   1 = break (F0 seen), 0 = make
//  frame_err    out  1   one-cycle pulse: bad start bit or parity
//  overflow     out  1   sticky; event dropped because output register was full; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, timeout counter 0; applies immediately, mid-sequence included.
//  Frame check on frame_valid:
//    bad if frame_in[0]!=0 or ^frame_in[9:1]!=1.
//    Bad -> frame_err=1 next cycle, FSM->IDLE, no event.
//  FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0,F0 seen). Data byte d=frame_in[8:1]:
//    IDLE:    d=E0->EXT;     d=F0->BRK;     else emit(d,ext=0,rel=0), stay IDLE
//    EXT:     d=F0->EXT_BRK; d=E0->stay EXT; else emit(d,1,0)->IDLE
//    BRK:     d=F0->stay BRK; d=E0->EXT_BRK; else emit(d,0,1)->IDLE
//    EXT_BRK: d=F0 or E0 -> stay;           else emit(d,1,1)->IDLE
//    All other bytes (incl. E1, AA, FA, FE) are ordinary codes.
//  Latency: event registered; key_valid rises the cycle after the completing frame_valid.
//  Output register, one deep:
//    key_* hold stable while key_valid=1 and key_ready=0.
//    key_valid clears the cycle after key_valid&key_ready unless a new event loads.
//  Simultaneous pop and emit: the new event loads in the same edge; no overflow.
//  Emit while full and not popping:
//    new event dropped, overflow<=1, register unchanged.
//    FSM still returns to IDLE.
//  Timeout:
//    counter resets on every frame_valid and counts only while FSM!=IDLE.
//    On reaching TIMEOUT_CYC-1: FSM->IDLE, counter->0, no event, no error.
//    frame_valid on the same cycle as expiry: the frame is processed against the current state; frame wins.
//  frame_valid is ignored while res=0; frames never queue internally; back-to-back strobes are legal.
// TESTING
//  1. frame 1C, key_ready=1 -> one key_valid pulse: code=1C ext=0 rel=0, 1 cycle after strobe
//  2. frames F0,1C -> single event code=1C rel=1 ext=0; no event after F0
//  3. frames E0,F0,75 with key_ready=0 ->
//       event 75 ext=1 rel=1 held stable for 20 cycles;
//       key_ready=1 -> key_valid=0 next cycle
//  4. frame 1C with bad parity, then 1C good ->
//       frame_err pulse once, then one event 1C;
//       bad frame during BRK also returns to IDLE
//  5. key_ready=0, frames 1C then 32 -> event 1C retained, overflow=1; pop+emit same cycle -> overflow stays 0
//  6. frame E0, wait TIMEOUT_CYC cycles, frame 1C -> event ext=0;
//     reset asserted after F0 -> all outputs 0, next 1C is a make

Source files
------------

// File: rtl/ps2_scan_decoder.sv
// ---------------------------------------------------------------------------
// ps2_scan_decoder
//
// Purpose:
//   Takes 10-bit PS/2 frames from the serial-to-parallel receiver, checks the
//   start and odd-parity bits, and follows the E0 (extended) and F0 (break)
//   prefix bytes. One make/break key event comes out per complete scan
//   sequence, through a one-deep output register with a valid/ready handshake.
//   It sits between the PS/2 frame receiver and the key-mapping/display logic.
//
// Parameters:
//   TIMEOUT_CYC  number of idle clk cycles before a pending prefix is dropped
//   TO_W         width of the timeout counter; TIMEOUT_CYC < 2**TO_W
//
// Ports:
//   clk          in   1   system clock, rising edge
//   res          in   1   asynchronous reset, active-low
//   frame_in     in   10  [0]=start, [8:1]=data LSB first, [9]=odd parity
//   frame_valid  in   1   one-cycle strobe, frame_in is valid this cycle
//   key_ready    in   1   consumer takes the event when key_valid & key_ready
//   key_valid    out  1   event waiting in the output register
//   key_code     out  8   scan code with the prefixes removed
//   key_ext      out  1   1 = the sequence contained E0
//   key_release  out  1   1 = break (F0 seen), 0 = make
//   frame_err    out  1   one-cycle pulse for a bad start bit or bad parity
//   overflow     out  1   sticky; an event was dropped because the register was full
//
// FSM states:
//   state   | meaning
//   --------+------------------------------------------
//   IDLE    | no prefix pending
//   EXT     | E0 received, waiting for the code or F0
//   BRK     | F0 received, waiting for the code
//   EXT_BRK | E0 and F0 received, waiting for the code
// ---------------------------------------------------------------------------
module ps2_scan_decoder #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int TO_W        = 16
) (
  input  logic       clk,
  input  logic       res,
  input  logic [9:0] frame_in,
  input  logic       frame_valid,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       frame_err,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0]      CODE_E0 = 8'hE0;
  localparam logic [7:0]      CODE_F0 = 8'hF0;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t          state;
  state_t          state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_nxt;

  logic [7:0] data;
  logic       frame_bad;
  logic       is_e0;
  logic       is_f0;
  logic       to_expire;
  logic       emit;
  logic       emit_ext;
  logic       emit_rel;
  logic       pop;

  assign data      = frame_in[8:1];
  // Parity is odd over data plus parity bit, so the reduction-XOR must be 1.
  assign frame_bad = frame_in[0] | ~(^frame_in[9:1]);
  assign is_e0     = (data == CODE_E0);
  assign is_f0     = (data == CODE_F0);
  assign to_expire = (state != IDLE) && (to_cnt == TO_LAST);
  assign pop       = key_valid & key_ready;

  // -------------------------------------------------------------------------
  // Prefix FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A frame arriving on the expiry cycle is decoded against the current
  // state, so the frame takes priority over the timeout.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_ext  = 1'b0;
    emit_rel  = 1'b0;
    if (frame_valid) begin
      if (frame_bad) begin
        state_nxt = IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (is_e0) begin
              state_nxt = EXT;
            end else if (is_f0) begin
              state_nxt = BRK;
            end else begin
              emit = 1'b1;
            end
          end
          EXT: begin
            if (is_f0) begin
              state_nxt = EXT_BRK;
            end else if (is_e0) begin
              state_nxt = EXT;
            end else begin
              emit      = 1'b1;
              emit_ext  = 1'b1;
              state_nxt = IDLE;
            end
          end
          BRK: begin
            if (is_f0) begin
              state_nxt = BRK;
            end else if (is_e0) begin
              state_nxt = EXT_BRK;
            end else begin
              emit      = 1'b1;
              emit_rel  = 1'b1;
              state_nxt = IDLE;
            end
          end
          EXT_BRK: begin
            if (is_f0 || is_e0) begin
              state_nxt = EXT_BRK;
            end else begin
              emit      = 1'b1;
              emit_ext  = 1'b1;
              emit_rel  = 1'b1;
              state_nxt = IDLE;
            end
          end
          default: begin
            state_nxt = IDLE;
          end
        endcase
      end
    end else if (to_expire) begin
      state_nxt = IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // Prefix timeout: cleared by every frame and held at zero in IDLE, so a
  // stale E0/F0 is discarded only after a quiet period inside a sequence.
  // -------------------------------------------------------------------------
  always_comb begin
    to_cnt_nxt = to_cnt;
    if (frame_valid || state == IDLE || to_expire) begin
      to_cnt_nxt = '0;
    end else begin
      to_cnt_nxt = to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Frame error pulse
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= frame_valid & frame_bad;
    end
  end

  // -------------------------------------------------------------------------
  // One-deep output register. A pop and a new event on the same edge load the
  // new event directly. An event that arrives while the register is full and
  // not being popped is dropped, and overflow is set.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      key_valid   <= 1'b0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (emit) begin
        if (!key_valid || pop) begin
          key_valid   <= 1'b1;
          key_code    <= data;
          key_ext     <= emit_ext;
          key_release <= emit_rel;
        end else begin
          overflow <= 1'b1;
        end
      end else if (pop) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
module tb_ps2_scan_decoder;

  localparam int T = 64;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic [9:0] frame_in = 10'h000;
  logic       frame_valid = 1'b0;
  logic       key_ready = 1'b0;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       frame_err;
  logic       overflow;

  ps2_scan_decoder #(.TIMEOUT_CYC(T), .TO_W(16)) dut (
    .clk(clk), .res(res), .frame_in(frame_in), .frame_valid(frame_valid),
    .key_ready(key_ready), .key_valid(key_valid), .key_code(key_code),
    .key_ext(key_ext), .key_release(key_release), .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: prefix flags plus a one-entry output slot.
  bit         m_ext_pend, m_brk_pend;
  bit         m_valid, m_ext, m_rel, m_err, m_ovf;
  logic [7:0] m_code;
  longint     cyc, last_frame;

  typedef struct {
    bit         fv;
    logic [7:0] d;
    bit   [1:0] bad;   // [0] bad parity, [1] bad start bit
    bit         rdy;
    bit         ev;
    logic [7:0] code;
    bit         ext;
    bit         rel;
    bit         err;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(bit fv, logic [7:0] d, bit [1:0] bad, bit rdy,
                             bit ev, logic [7:0] code, bit ext, bit rel, bit err);
    vec_t r;
    r.fv = fv; r.d = d; r.bad = bad; r.rdy = rdy; r.ev = ev;
    r.code = code; r.ext = ext; r.rel = rel; r.err = err;
    return r;
  endfunction

  function automatic logic [9:0] mk_frame(logic [7:0] d, bit [1:0] bad);
    return {(~^d) ^ bad[0], d, bad[1]};
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0b expected %0b", name, act, exp);
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  task automatic model_reset();
    m_ext_pend = 0; m_brk_pend = 0;
    m_valid = 0; m_ext = 0; m_rel = 0; m_err = 0; m_ovf = 0;
    m_code = 8'h00;
  endtask

  task automatic model_edge(input bit fv, input logic [9:0] f, input bit rdy);
    bit         bad, emit, ee, er, pop;
    logic [7:0] d;
    cyc++;
    emit = 0; ee = 0; er = 0;
    d    = f[8:1];
    bad  = (f[0] != 1'b0) || ((^f[9:1]) != 1'b1);
    if (fv) begin
      last_frame = cyc;
      if (bad) begin
        m_ext_pend = 0; m_brk_pend = 0;
      end else if (d == 8'hE0) begin
        m_ext_pend = 1;
      end else if (d == 8'hF0) begin
        m_brk_pend = 1;
      end else begin
        emit = 1; ee = m_ext_pend; er = m_brk_pend;
        m_ext_pend = 0; m_brk_pend = 0;
      end
    end else if ((m_ext_pend || m_brk_pend) && (cyc - last_frame == longint'(T))) begin
      m_ext_pend = 0; m_brk_pend = 0;
    end
    pop = m_valid && rdy;
    if (emit) begin
      if (!m_valid || pop) begin
        m_valid = 1; m_code = d; m_ext = ee; m_rel = er;
      end else begin
        m_ovf = 1;
      end
    end else if (pop) begin
      m_valid = 0;
    end
    m_err = fv && bad;
  endtask

  task automatic compare_model();
    chk1("model.key_valid", key_valid, m_valid);
    chk1("model.frame_err", frame_err, m_err);
    chk1("model.overflow", overflow, m_ovf);
    if (m_valid) begin
      chk8("model.key_code", key_code, m_code);
      chk1("model.key_ext", key_ext, m_ext);
      chk1("model.key_release", key_release, m_rel);
    end
  endtask

  // Called at a negedge: drive, clock once, update model, compare at next negedge.
  task automatic step(input bit fv, input logic [7:0] d, input bit [1:0] bad, input bit rdy);
    frame_valid = fv;
    frame_in    = mk_frame(d, bad);
    key_ready   = rdy;
    @(posedge clk);
    model_edge(fv, mk_frame(d, bad), rdy);
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 8'h00, 2'b00, rdy);
  endtask

  task automatic do_reset();
    res = 1'b0;
    model_reset();
    #1;
    chk1("reset.key_valid", key_valid, 1'b0);
    chk8("reset.key_code", key_code, 8'h00);
    chk1("reset.key_ext", key_ext, 1'b0);
    chk1("reset.key_release", key_release, 1'b0);
    chk1("reset.frame_err", frame_err, 1'b0);
    chk1("reset.overflow", overflow, 1'b0);
    frame_valid = 1'b1;
    frame_in    = mk_frame(8'h1C, 2'b00);
    key_ready   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk1("reset.ignore_frame", key_valid, 1'b0);
    frame_valid = 1'b0;
    res = 1'b1;
  endtask

  initial begin
    int r;
    logic [7:0] d;
    bit [1:0] bad;
    model_reset();
    cyc = 0; last_frame = 0;
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Directed table, consumer always ready.
    vt.push_back(v(1, 8'h1C, 0, 1, 1, 8'h1C, 0, 0, 0));
    vt.push_back(v(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0));
    vt.push_back(v(1, 8'hF0, 0, 1, 0, 8'h00, 0, 0, 0));
    vt.push_back(v(1, 8'h1C, 0, 1, 1, 8'h1C, 0, 1, 0));
    vt.push_back(v(1, 8'hE0, 0, 1, 0, 8'h00, 0, 0, 0));
    vt.push_back(v(1, 8'hF0, 0, 1, 0, 8'h00, 0, 0, 0));
    vt.push_back(v(1, 8'h75, 0, 1, 1, 8'h75, 1, 1, 0));
    vt.push_back(v(1, 8'h1C, 1, 1, 0, 8'h00, 0, 0, 1));
    vt.push_back(v(1, 8'h1C, 0, 1, 1, 8'h1C, 0, 0, 0));
    vt.push_back(v(1, 8'hF0, 0, 1, 0, 8'h00, 0, 0, 0));
    vt.push_back(v(1, 8'h32, 1, 1, 0, 8'h00, 0, 0, 1));
    vt.push_back(v(1, 8'h32, 0, 1, 1, 8'h32, 0, 0, 0));
    vt.push_back(v(1, 8'hE1, 0, 1, 1, 8'hE1, 0, 0, 0));
    vt.push_back(v(1, 8'hE0, 0, 1, 0, 8'h00, 0, 0, 0));
    vt.push_back(v(1, 8'hE0, 0, 1, 0, 8'h00, 0, 0, 0));
    vt.push_back(v(1, 8'hAA, 0, 1, 1, 8'hAA, 1, 0, 0));
    vt.push_back(v(1, 8'hF0, 0, 1, 0, 8'h00, 0, 0, 0));
    vt.push_back(v(1, 8'hE0, 0, 1, 0, 8'h00, 0, 0, 0));
    vt.push_back(v(1, 8'hFA, 0, 1, 1, 8'hFA, 1, 1, 0));
    vt.push_back(v(1, 8'h1C, 2, 1, 0, 8'h00, 0, 0, 1));
    vt.push_back(v(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0));
    foreach (vt[i]) begin
      step(vt[i].fv, vt[i].d, vt[i].bad, vt[i].rdy);
      chk1($sformatf("tbl[%0d].valid", i), key_valid, vt[i].ev);
      chk1($sformatf("tbl[%0d].err", i), frame_err, vt[i].err);
      if (vt[i].ev) begin
        chk8($sformatf("tbl[%0d].code", i), key_code, vt[i].code);
        chk1($sformatf("tbl[%0d].ext", i), key_ext, vt[i].ext);
        chk1($sformatf("tbl[%0d].rel", i), key_release, vt[i].rel);
      end
    end

    // Held event with consumer stalled, then popped.
    step(1, 8'hE0, 0, 0);
    step(1, 8'hF0, 0, 0);
    step(1, 8'h75, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 8'h00, 0, 0);
      chk1("hold.valid", key_valid, 1'b1);
      chk8("hold.code", key_code, 8'h75);
      chk1("hold.ext", key_ext, 1'b1);
      chk1("hold.rel", key_release, 1'b1);
    end
    step(0, 8'h00, 0, 1);
    chk1("hold.popped", key_valid, 1'b0);

    // Overflow on a full register, and none on a simultaneous pop+emit.
    do_reset();
    step(1, 8'h1C, 0, 0);
    step(1, 8'h32, 0, 0);
    chk1("ovf.valid", key_valid, 1'b1);
    chk8("ovf.code_kept", key_code, 8'h1C);
    chk1("ovf.flag", overflow, 1'b1);
    idle(3, 0);
    chk1("ovf.sticky", overflow, 1'b1);
    do_reset();
    step(1, 8'h1C, 0, 0);
    step(1, 8'h32, 0, 1);
    chk1("popemit.valid", key_valid, 1'b1);
    chk8("popemit.code", key_code, 8'h32);
    chk1("popemit.no_ovf", overflow, 1'b0);
    step(0, 8'h00, 0, 1);
    chk1("popemit.drained", key_valid, 1'b0);

    // Timeout drops a stale E0.
    step(1, 8'hE0, 0, 1);
    idle(T, 1);
    step(1, 8'h1C, 0, 1);
    chk1("timeout.valid", key_valid, 1'b1);
    chk1("timeout.ext_dropped", key_ext, 1'b0);
    step(0, 8'h00, 0, 1);
    // Frame on the expiry cycle is decoded against the pending prefix.
    step(1, 8'hE0, 0, 1);
    idle(T - 1, 1);
    step(1, 8'h1C, 0, 1);
    chk1("expiry_edge.valid", key_valid, 1'b1);
    chk1("expiry_edge.ext_kept", key_ext, 1'b1);
    step(0, 8'h00, 0, 1);

    // Reset in the middle of a break sequence.
    step(1, 8'hF0, 0, 1);
    do_reset();
    step(1, 8'h1C, 0, 1);
    chk1("rst_mid.valid", key_valid, 1'b1);
    chk1("rst_mid.make", key_release, 1'b0);
    step(0, 8'h00, 0, 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        idle($urandom_range(T - 2, T + 2), $urandom_range(0, 3) != 0);
      end else if (r < 3) begin
        do_reset();
      end else begin
        r = $urandom_range(0, 9);
        if (r < 2) d = 8'hE0;
        else if (r < 4) d = 8'hF0;
        else d = 8'($urandom_range(0, 255));
        bad = 2'b00;
        if ($urandom_range(0, 9) == 0) bad = 2'($urandom_range(1, 3));
        step($urandom_range(0, 3) != 0, d, bad, $urandom_range(0, 3) != 0);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
